alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle sequencer that owns the control inputs of the 16-bit 74181-based ALU/shifter datapath (`alu`). It accepts one operation at a time from the CPU control unit over a req/done handshake and drives the ALU function, carry-select and output-enable lines. It holds the A/B operand registers, iterates single-bit shifts to implement shift-by-N, and registers the result and the carry and zero flags.

## Interface
Parameters: none.
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  start request; sampled only when `busy`=0
- `op`  in  4  operation code, sampled at accept
- `amt`  in  4  shift amount, sampled at accept (SHL/SHR only)
- `opa`, `opb`  in  16  operands, sampled at accept
- `busy`  out  1  operation in progress; `req` is ignored
- `done`  out  1  one-cycle pulse; `result` and flags are valid
- `result`  out  16  registered result
- `carry`, `zero`  out  1  registered flags
- `alu_a`, `alu_b`  out  16  ALU operands, driven from internal `areg` and `breg`
- `alu_y`  in  16  ALU/shifter bus
- `alu_cout`, `alu_zout`  in  1  ALU carry out and zero out
- `alu_f`  out  5  {S3..S0, M}; the shifter reads f[2:0]
- `alu_csel`, `alu_ucin`, `alu_fcin`  out  1  carry-in select (0 = ucin, 1 = fcin), user carry, flag carry (`alu_fcin` = `carry`)
- `alu_notALUOE`, `alu_notShiftOE`  out  1  active-low output enables; never both low

## Operation
Opcodes and `alu_f`, `csel`, `ucin`:
- 0 ADD: 10010, 0, 0
- 1 ADC: 10010, 1, –
- 2 SUB: 01100, 0, 1
- 3 SBC: 01100, 1, –
- 4 AND: 10111
- 5 OR: 11101
- 6 XOR: 01101
- 7 NOT A: 00001
- 8 MOV B: 10101
- 9 SHL: 00101, shifter enabled
- 10 SHR: 00010, shifter enabled
- 11–15: illegal

For the logic ops and MOV B, `csel` and `ucin` are 0.

State machine:
- IDLE: no operation.
- EXEC: single-cycle ALU operation.
- SHIFT: one cycle per bit of the shift.
- DONE: result presented.

Transitions:
- IDLE/DONE + `req`: load `areg`/`breg`, latch `op`, set `cnt`=`amt`.
- Shift op with `amt`≠0 goes to SHIFT. Any other op goes to EXEC.
- EXEC → DONE.
- SHIFT: each cycle `areg` ← `alu_y` and `carry` ← `alu_cout`; `cnt` decrements. When `cnt`=1, register `result` and `zero`, then go to DONE.
- DONE → IDLE when `req`=0.

Outputs and flag rules:
- In IDLE and DONE: both OEs high, `alu_f`=0, `csel`=`ucin`=0.
- `busy` = EXEC or SHIFT.
- `done` = 1 in DONE.
- EXEC registers `result`←`alu_y` and `zero`←`alu_zout`. Arithmetic ops also set `carry`←`alu_cout`; logic ops and MOV leave `carry` unchanged.
- `carry` semantics: 1 = carry out, or no borrow for SUB/SBC.
- Shift with `amt`=0: runs EXEC with MOV-A function 11111. `result`=`opa`, `carry` unchanged.
- Illegal op: takes the EXEC cycle with both OEs high. `result` and all flags unchanged; `done` still pulses.

Boundary conditions:
- `req` while `busy` is dropped, not queued.
- `req` during DONE is accepted, giving back-to-back operation.
- ADC/SBC use the value of `carry` at accept.

## Timing
- Reset: state IDLE; `areg`, `breg`, `result`, `cnt` = 0; `carry`=`zero`=`done`=`busy`=0; both OEs high. Reset asserted mid-operation releases the ALU bus immediately and aborts the operation.
- Accept on edge T: EXEC runs in cycle T+1, and `done`=1 in T+2. Single-cycle op latency is 2 cycles.
- Shift by N (1–15): SHIFT runs in cycles T+1..T+N, and `done` follows in T+N+1.
- Full ALU combinational settle must fit within one `clk` period.

## Configuration
- `ALU_SEQ_CMP_EN` defined: opcode 11 = CMP. It uses the SUB controls and updates `carry`/`zero`, but `result` is unchanged.
- Undefined: opcode 11 is illegal.

## Test plan
- ADD `opa`=0x7FFF, `opb`=0x0001 → `result`=0x8000, `carry`=0, `zero`=0, `done` exactly 2 cycles after accept.
- SUB 0x0005−0x0005 → `result`=0x0000, `carry`=1, `zero`=1. Then ADC 0xFFFF+0x0000 with `csel`=1 → 0x0000, `carry`=1, `zero`=1.
- SHL 0x8001, `amt`=4 → `result`=0x0010, `carry`=0. `alu_notShiftOE` low for exactly 4 cycles, `done` at T+5. SHR 0x0003, `amt`=1 → 0x0001, `carry`=1.
- `req` held during SHIFT and at DONE → the mid-shift request is ignored. Exactly one new accept occurs at DONE, with no idle cycle between operations.
- Reset asserted in the 2nd SHIFT cycle → OEs high, `busy`=0, `result`=0 immediately. Opcode 13 → `done` pulses, `result` and flags unchanged; opcode 11 behaves according to `ALU_SEQ_CMP_EN`.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer driving the control lines of the 74181-based ALU/shifter datapath.
// Optional feature: define ALU_SEQ_CMP_EN to decode opcode 11 as CMP (SUB controls, flags only).
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [3:0]  amt,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic        alu_cout,
    input  logic        alu_zout,
    output logic [4:0]  alu_f,
    output logic        alu_csel,
    output logic        alu_ucin,
    output logic        alu_fcin,
    output logic        alu_notALUOE,
    output logic        alu_notShiftOE
);
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpAdc  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSbc  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpNot  = 4'd7;
    localparam logic [3:0] OpMovB = 4'd8;
    localparam logic [3:0] OpShl  = 4'd9;
    localparam logic [3:0] OpShr  = 4'd10;
    localparam logic [3:0] OpCmp  = 4'd11;

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_t;

    state_t      r_state;
    logic [15:0] r_areg, r_breg, r_result;
    logic [3:0]  r_op, r_cnt;
    logic        r_carry, r_zero, r_busy, r_done;
    logic [4:0]  r_f;
    logic        r_csel, r_ucin, r_nalu_oe, r_nsh_oe;

    logic [4:0]  w_f;
    logic        w_csel, w_ucin, w_alu_en, w_sh_en, w_go_shift;
    logic        w_arith, w_upd_res, w_legal;

    // Control decode of the incoming opcode, registered at accept.
    always_comb begin
        w_f      = 5'b00000;
        w_csel   = 1'b0;
        w_ucin   = 1'b0;
        w_alu_en = 1'b1;
        w_sh_en  = 1'b0;
        case (op)
            OpAdd:  w_f = 5'b10010;
            OpAdc:  begin w_f = 5'b10010; w_csel = 1'b1; end
            OpSub:  begin w_f = 5'b01100; w_ucin = 1'b1; end
            OpSbc:  begin w_f = 5'b01100; w_csel = 1'b1; end
            OpAnd:  w_f = 5'b10111;
            OpOr:   w_f = 5'b11101;
            OpXor:  w_f = 5'b01101;
            OpNot:  w_f = 5'b00001;
            OpMovB: w_f = 5'b10101;
            OpShl, OpShr: begin
                if (amt == 4'd0) begin
                    w_f = 5'b11111;
                end else begin
                    w_f      = (op == OpShl) ? 5'b00101 : 5'b00010;
                    w_alu_en = 1'b0;
                    w_sh_en  = 1'b1;
                end
            end
`ifdef ALU_SEQ_CMP_EN
            OpCmp:  begin w_f = 5'b01100; w_ucin = 1'b1; end
`endif
            default: w_alu_en = 1'b0;
        endcase
    end

    assign w_go_shift = ((op == OpShl) || (op == OpShr)) && (amt != 4'd0);

    // Which registers the EXEC cycle updates for the latched opcode.
    always_comb begin
        w_arith   = (r_op <= OpSbc);
        w_upd_res = (r_op <= OpShr);
        w_legal   = w_upd_res;
`ifdef ALU_SEQ_CMP_EN
        if (r_op == OpCmp) begin
            w_arith = 1'b1;
            w_legal = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_areg    <= 16'h0000;
            r_breg    <= 16'h0000;
            r_result  <= 16'h0000;
            r_op      <= 4'd0;
            r_cnt     <= 4'd0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_f       <= 5'b00000;
            r_csel    <= 1'b0;
            r_ucin    <= 1'b0;
            r_nalu_oe <= 1'b1;
            r_nsh_oe  <= 1'b1;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (req) begin
                        r_areg    <= opa;
                        r_breg    <= opb;
                        r_op      <= op;
                        r_cnt     <= amt;
                        r_f       <= w_f;
                        r_csel    <= w_csel;
                        r_ucin    <= w_ucin;
                        r_nalu_oe <= ~w_alu_en;
                        r_nsh_oe  <= ~w_sh_en;
                        r_busy    <= 1'b1;
                        r_state   <= w_go_shift ? StShift : StExec;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StExec: begin
                    if (w_upd_res) r_result <= alu_y;
                    if (w_legal)   r_zero   <= alu_zout;
                    if (w_arith)   r_carry  <= alu_cout;
                    r_f       <= 5'b00000;
                    r_csel    <= 1'b0;
                    r_ucin    <= 1'b0;
                    r_nalu_oe <= 1'b1;
                    r_nsh_oe  <= 1'b1;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= StDone;
                end
                StShift: begin
                    r_areg  <= alu_y;
                    r_carry <= alu_cout;
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_result  <= alu_y;
                        r_zero    <= alu_zout;
                        r_f       <= 5'b00000;
                        r_nsh_oe  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign result         = r_result;
    assign carry          = r_carry;
    assign zero           = r_zero;
    assign alu_a          = r_areg;
    assign alu_b          = r_breg;
    assign alu_f          = r_f;
    assign alu_csel       = r_csel;
    assign alu_ucin       = r_ucin;
    assign alu_fcin       = r_carry;
    assign alu_notALUOE   = r_nalu_oe;
    assign alu_notShiftOE = r_nsh_oe;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: behavioural 74181/shifter model around alu_seq; expected completions are queued
// at issue time and a monitor branch pops and compares them whenever done is seen.
module tb_alu_seq;
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpAdc  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSbc  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpNot  = 4'd7;
    localparam logic [3:0] OpMovB = 4'd8;
    localparam logic [3:0] OpShl  = 4'd9;
    localparam logic [3:0] OpShr  = 4'd10;
    localparam logic [3:0] Op11   = 4'd11;
    localparam logic [3:0] Op13   = 4'd13;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [3:0]  amt = 4'd0;
    logic [15:0] opa = 16'h0;
    logic [15:0] opb = 16'h0;
    logic        busy, done, carry, zero;
    logic [15:0] result, alu_a, alu_b, alu_y;
    logic        alu_cout, alu_zout;
    logic [4:0]  alu_f;
    logic        alu_csel, alu_ucin, alu_fcin, alu_notALUOE, alu_notShiftOE;

    alu_seq u_dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .op             (op),
        .amt            (amt),
        .opa            (opa),
        .opb            (opb),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .carry          (carry),
        .zero           (zero),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_y          (alu_y),
        .alu_cout       (alu_cout),
        .alu_zout       (alu_zout),
        .alu_f          (alu_f),
        .alu_csel       (alu_csel),
        .alu_ucin       (alu_ucin),
        .alu_fcin       (alu_fcin),
        .alu_notALUOE   (alu_notALUOE),
        .alu_notShiftOE (alu_notShiftOE)
    );

    always #5 clk = ~clk;

    // Datapath model: 74181 functions used by the sequencer, plus the 1-bit shifter.
    logic [16:0] w_sum;
    logic        w_cin;
    always_comb begin
        w_sum    = 17'h0;
        w_cin    = alu_csel ? alu_fcin : alu_ucin;
        alu_y    = 16'hFFFF;
        alu_cout = 1'b0;
        if (!alu_notALUOE && !alu_notShiftOE) begin
            alu_y = 16'hDEAD;
        end else if (!alu_notALUOE) begin
            case (alu_f)
                5'b10010: begin
                    w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, w_cin};
                    alu_y = w_sum[15:0]; alu_cout = w_sum[16];
                end
                5'b01100: begin
                    w_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, w_cin};
                    alu_y = w_sum[15:0]; alu_cout = w_sum[16];
                end
                5'b10111: alu_y = alu_a & alu_b;
                5'b11101: alu_y = alu_a | alu_b;
                5'b01101: alu_y = alu_a ^ alu_b;
                5'b00001: alu_y = ~alu_a;
                5'b10101: alu_y = alu_b;
                5'b11111: alu_y = alu_a;
                default:  alu_y = 16'hBAD0;
            endcase
        end else if (!alu_notShiftOE) begin
            case (alu_f[2:0])
                3'b101:  begin alu_y = {alu_a[14:0], 1'b0}; alu_cout = alu_a[15]; end
                3'b010:  begin alu_y = {1'b0, alu_a[15:1]}; alu_cout = alu_a[0]; end
                default: alu_y = 16'hBAD1;
            endcase
        end
    end
    assign alu_zout = (alu_y == 16'h0000);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sh_cnt = 0;
    always @(negedge clk) if (!alu_notShiftOE) sh_cnt <= sh_cnt + 1;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int   n_chk = 0;
    int   n_err = 0;
    logic both_low_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [15:0] r, input logic c, input logic z, input int dcyc);
        exp_t e;
        e.res = r; e.c = c; e.z = z; e.cyc = dcyc;
        sb_q.push_back(e);
    endtask

    // Presents one request for one cycle; returns at the negedge of the first busy cycle.
    task automatic issue(input logic [3:0] o, input logic [3:0] n, input logic [15:0] a,
                         input logic [15:0] b, input int lat, input logic [15:0] er,
                         input logic ec, input logic ez);
        @(negedge clk);
        req = 1'b1; op = o; amt = n; opa = a; opb = b;
        push(er, ec, ez, cyc + lat);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic to_done(input int lat);
        repeat (lat - 1) @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!alu_notALUOE && !alu_notShiftOE) both_low_seen = 1'b1;
                    if (!reset && done) begin
                        if (sb_q.size() == 0) begin
                            n_chk++; n_err++;
                            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                        end else begin
                            e = sb_q.pop_front();
                            chk("done_cycle", cyc, e.cyc);
                            chk("result", result, e.res);
                            chk("carry", carry, e.c);
                            chk("zero", zero, e.z);
                        end
                    end
                end
            end
            begin : stimulus
                int s0;
                int c;
                repeat (2) @(negedge clk);
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_result", result, 0);
                chk("rst_carry", carry, 0);
                chk("rst_zero", zero, 0);
                chk("rst_alu_oe", alu_notALUOE, 1);
                chk("rst_sh_oe", alu_notShiftOE, 1);
                chk("rst_alu_f", alu_f, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_b", alu_b, 0);
                reset = 1'b0;

                issue(OpAdd, 4'd0, 16'h7FFF, 16'h0001, 2, 16'h8000, 1'b0, 1'b0);
                chk("add_busy", busy, 1);
                chk("add_alu_f", alu_f, 5'b10010);
                to_done(2);
                issue(OpSub, 4'd0, 16'h0005, 16'h0005, 2, 16'h0000, 1'b1, 1'b1);
                chk("sub_ucin", alu_ucin, 1);
                to_done(2);
                issue(OpAdc, 4'd0, 16'hFFFF, 16'h0000, 2, 16'h0000, 1'b1, 1'b1);
                chk("adc_csel", alu_csel, 1);
                chk("adc_fcin", alu_fcin, 1);
                to_done(2);
                issue(OpAnd, 4'd0, 16'hF0F0, 16'h3C3C, 2, 16'h3030, 1'b1, 1'b0);
                to_done(2);
                issue(OpXor, 4'd0, 16'hAAAA, 16'hAAAA, 2, 16'h0000, 1'b1, 1'b1);
                to_done(2);
                issue(OpOr, 4'd0, 16'h1200, 16'h0034, 2, 16'h1234, 1'b1, 1'b0);
                to_done(2);
                issue(OpNot, 4'd0, 16'h00FF, 16'h0000, 2, 16'hFF00, 1'b1, 1'b0);
                to_done(2);
                issue(OpMovB, 4'd0, 16'h1111, 16'hBEEF, 2, 16'hBEEF, 1'b1, 1'b0);
                to_done(2);
                issue(OpSub, 4'd0, 16'h0003, 16'h0004, 2, 16'hFFFF, 1'b0, 1'b0);
                to_done(2);
                issue(OpSbc, 4'd0, 16'h0010, 16'h0003, 2, 16'h000C, 1'b1, 1'b0);
                chk("sbc_fcin", alu_fcin, 0);
                to_done(2);

                s0 = sh_cnt;
                issue(OpShl, 4'd4, 16'h8001, 16'h0000, 5, 16'h0010, 1'b0, 1'b0);
                chk("shl_alu_f", alu_f, 5'b00101);
                chk("shl_alu_oe", alu_notALUOE, 1);
                to_done(5);
                chk("shl_oe_cycles", sh_cnt - s0, 4);
                issue(OpShr, 4'd1, 16'h0003, 16'h0000, 2, 16'h0001, 1'b1, 1'b0);
                to_done(2);
                issue(OpShl, 4'd0, 16'h5A5A, 16'h0000, 2, 16'h5A5A, 1'b1, 1'b0);
                chk("shl0_alu_f", alu_f, 5'b11111);
                chk("shl0_sh_oe", alu_notShiftOE, 1);
                to_done(2);
                issue(Op13, 4'd0, 16'h0001, 16'h0002, 2, 16'h5A5A, 1'b1, 1'b0);
                chk("ill_alu_oe", alu_notALUOE, 1);
                chk("ill_sh_oe", alu_notShiftOE, 1);
                to_done(2);
`ifdef ALU_SEQ_CMP_EN
                issue(Op11, 4'd0, 16'h0005, 16'h0007, 2, 16'h5A5A, 1'b0, 1'b0);
`else
                issue(Op11, 4'd0, 16'h0005, 16'h0007, 2, 16'h5A5A, 1'b1, 1'b0);
`endif
                to_done(2);

                // req held through a shift; the follow-on op is taken in the DONE cycle.
                @(negedge clk);
                c = cyc;
                req = 1'b1; op = OpShl; amt = 4'd3; opa = 16'h0001; opb = 16'h0000;
                push(16'h0008, 1'b0, 1'b0, c + 4);
                @(negedge clk);
                op = OpAdd; amt = 4'd0; opa = 16'h0002; opb = 16'h0003;
                push(16'h0005, 1'b0, 1'b0, c + 6);
                repeat (4) @(negedge clk);
                req = 1'b0;
                chk("b2b_busy", busy, 1);
                repeat (2) @(negedge clk);

                // Reset during the second shift cycle.
                @(negedge clk);
                req = 1'b1; op = OpShl; amt = 4'd5; opa = 16'h00F0; opb = 16'h0000;
                @(negedge clk);
                req = 1'b0;
                @(negedge clk);
                chk("mid_sh_busy", busy, 1);
                reset = 1'b1;
                #1;
                chk("mid_rst_alu_oe", alu_notALUOE, 1);
                chk("mid_rst_sh_oe", alu_notShiftOE, 1);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_result", result, 0);
                chk("mid_rst_done", done, 0);
                @(negedge clk);
                reset = 1'b0;
                repeat (4) @(negedge clk);

                issue(OpAdd, 4'd0, 16'h0001, 16'h0001, 2, 16'h0002, 1'b0, 1'b0);
                to_done(2);
                repeat (3) @(negedge clk);
                chk("sb_empty", sb_q.size(), 0);
                chk("oe_never_both_low", both_low_seen, 0);
            end
            begin : watchdog
                #200000;
                n_chk++; n_err++;
                $display("FAIL timeout: got no end of stimulus expected end before 200000 time units");
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
